// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI transaction controller.
//   spi_state_t  - controller FSM states
//   SPI_CPOL/CPHA - SPI mode 0 constants (SCLK idles low)
//   half_cycles() - clocks per SCLK phase for a given EXP_FACTOR
//   half_cnt_w()  - width of the phase counter (at least 1 bit)
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4
    } spi_state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    function automatic int unsigned half_cycles(input int unsigned exp_factor);
        return 32'd1 << (exp_factor - 32'd1);
    endfunction

    // Counter runs 0..HALF-1, i.e. exp_factor-1 bits; HALF=1 still needs one bit.
    function automatic int unsigned half_cnt_w(input int unsigned exp_factor);
        return (exp_factor > 32'd1) ? (exp_factor - 32'd1) : 32'd1;
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// spi_bit_timer: SCLK phase timer, active only while the controller shifts.
//   clk, rst  - system clock, synchronous active-high reset
//   en        - high while the FSM is in SHIFT; low clears all counters
//   rise_stb  - the coming edge ends a low phase (SCLK should go high)
//   fall_stb  - the coming edge ends a high phase (SCLK low, sample, advance)
//   bit_idx   - index of the bit period in progress, 0 = MSB
module spi_bit_timer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned EXP_FACTOR = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic                      rise_stb,
    output logic                      fall_stb,
    output logic [$clog2(DATA_W)-1:0] bit_idx
);

    localparam int unsigned HALF = half_cycles(EXP_FACTOR);
    localparam int unsigned HC_W = half_cnt_w(EXP_FACTOR);
    localparam int unsigned BI_W = $clog2(DATA_W);

    logic [HC_W-1:0] half_cnt;
    logic            phase_hi;
    logic            half_done;
    logic            last_bit;

    assign half_done = en && (half_cnt == HC_W'(HALF - 1));
    assign rise_stb  = half_done && !phase_hi;
    assign fall_stb  = half_done && phase_hi;
    assign last_bit  = (bit_idx == BI_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            half_cnt <= '0;
            phase_hi <= 1'b0;
            bit_idx  <= '0;
        end else if (half_done) begin
            half_cnt <= '0;
            phase_hi <= !phase_hi;
            // Index saturates on the last bit; the FSM leaves SHIFT on that edge.
            if (phase_hi && !last_bit) begin
                bit_idx <= bit_idx + BI_W'(1);
            end
        end else begin
            half_cnt <= half_cnt + HC_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: one SPI mode-0 transaction per accepted request.
//   clock_i, reset_i       - system clock, synchronous active-high reset
//   req_valid_i/ready_o    - request handshake; tx_data_i latched on accept
//   rsp_valid_o, rx_data_o - one-cycle response pulse, rx word held after
//   busy_o                 - high whenever not IDLE
//   SCLK_o, CS_n_o, MOSI_o - SPI outputs (all registered); MISO_i - SPI input
// Sequence: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> IDLE.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned EXP_FACTOR   = 6,
    parameter int unsigned CS_SETUP_CYC = 4,
    parameter int unsigned CS_HOLD_CYC  = 4,
    parameter int unsigned CS_GAP_CYC   = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              SCLK_o,
    output logic              CS_n_o,
    output logic              MOSI_o,
    input  logic              MISO_i
);

    localparam int unsigned PH_MAX_SH = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int unsigned PH_MAX    = (PH_MAX_SH > CS_GAP_CYC) ? PH_MAX_SH : CS_GAP_CYC;
    localparam int unsigned PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned BI_W      = $clog2(DATA_W);

    spi_state_t        state;
    logic [PH_W-1:0]   ph_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              rise_stb;
    logic              fall_stb;
    logic [BI_W-1:0]   bit_idx;
    logic              last_bit;

    assign last_bit = (bit_idx == BI_W'(DATA_W - 1));

    spi_bit_timer #(
        .DATA_W    (DATA_W),
        .EXP_FACTOR(EXP_FACTOR)
    ) u_bit_timer (
        .clk     (clock_i),
        .rst     (reset_i),
        .en      (state == SHIFT),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb),
        .bit_idx (bit_idx)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rx_data_o   <= '0;
            busy_o      <= 1'b0;
            SCLK_o      <= SPI_CPOL;
            CS_n_o      <= 1'b1;
            MOSI_o      <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        state       <= CS_SETUP;
                        ph_cnt      <= '0;
                        tx_sr       <= tx_data_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        CS_n_o      <= 1'b0;
                        MOSI_o      <= tx_data_i[DATA_W-1];
                    end
                end
                CS_SETUP: begin
                    if (ph_cnt == PH_W'(CS_SETUP_CYC - 1)) begin
                        state  <= SHIFT;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                SHIFT: begin
                    if (rise_stb) begin
                        SCLK_o <= 1'b1;
                    end
                    // Falling edge: sample MISO, then either advance MOSI or finish
                    // (MOSI keeps the final bit through CS_HOLD).
                    if (fall_stb) begin
                        SCLK_o <= SPI_CPOL;
                        rx_sr  <= {rx_sr[DATA_W-2:0], MISO_i};
                        if (last_bit) begin
                            state  <= CS_HOLD;
                            ph_cnt <= '0;
                        end else begin
                            tx_sr  <= tx_sr << 1;
                            MOSI_o <= tx_sr[DATA_W-2];
                        end
                    end
                end
                CS_HOLD: begin
                    if (ph_cnt == PH_W'(CS_HOLD_CYC - 1)) begin
                        state       <= GAP;
                        ph_cnt      <= '0;
                        CS_n_o      <= 1'b1;
                        MOSI_o      <= 1'b0;
                        rx_data_o   <= rx_sr;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                GAP: begin
                    if (ph_cnt == PH_W'(CS_GAP_CYC - 1)) begin
                        state       <= IDLE;
                        ph_cnt      <= '0;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed + randomized checks of spi_xfer_ctrl against
// expectations computed from the transaction timing rules.
module tb_spi_xfer_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned EXP   = 2;
    localparam int unsigned SETUP = 2;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned GAPC  = 3;
    localparam int HALF_C      = 1 << (EXP - 1);
    localparam int CS_LOW_EXP  = SETUP + 2 * HALF_C * DW + HOLD;
    localparam int SPACING_EXP = CS_LOW_EXP + GAPC + 1;
    localparam int CS_GAP_EXP  = GAPC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          req_ready, rsp_valid, busy, sclk, cs_n, mosi, miso;
    logic [DW-1:0] rx_data;

    // MISO source: loopback of MOSI, or a word presented MSB first, one bit
    // per SCLK period, changing just after each SCLK fall.
    logic          loop_mode = 1'b1;
    logic [DW-1:0] pattern = '0;
    int            miso_idx = 0;
    assign miso = loop_mode ? mosi : ((miso_idx < DW) ? pattern[DW-1-miso_idx] : 1'b0);

    spi_xfer_ctrl #(
        .DATA_W      (DW),
        .EXP_FACTOR  (EXP),
        .CS_SETUP_CYC(SETUP),
        .CS_HOLD_CYC (HOLD),
        .CS_GAP_CYC  (GAPC)
    ) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .tx_data_i  (tx_data),
        .rsp_valid_o(rsp_valid),
        .rx_data_o  (rx_data),
        .busy_o     (busy),
        .SCLK_o     (sclk),
        .CS_n_o     (cs_n),
        .MOSI_o     (mosi),
        .MISO_i     (miso)
    );

    always #5 clk = ~clk;

    // Bus monitor: cumulative counters sampled on the falling clock edge.
    int            cyc = 0, rise_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
    int            last_acc = 0, prev_acc = 0;
    int            cs_low_run = 0, cs_high_run = 0, last_cs_low_len = 0, last_cs_high_len = 0;
    int            viol = 0, mosi_ones = 0, sclk_high_cyc = 0, cs_low_cyc = 0;
    logic          prev_sclk = 1'b0, prev_busy = 1'b0;
    logic [DW-1:0] mosi_hist = '0;
    logic [DW-1:0] rx_log [0:63];

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_sclk <= sclk;
        prev_busy <= busy;
        if (sclk && !prev_sclk) begin
            rise_cnt  <= rise_cnt + 1;
            mosi_hist <= {mosi_hist[DW-2:0], mosi};
        end
        if (cs_n) miso_idx <= 0;
        else if (!sclk && prev_sclk) miso_idx <= miso_idx + 1;
        if (busy && !prev_busy) begin
            acc_cnt  <= acc_cnt + 1;
            prev_acc <= last_acc;
            last_acc <= cyc;
        end
        if (rsp_valid) begin
            rsp_cnt             <= rsp_cnt + 1;
            rx_log[rsp_cnt % 64] <= rx_data;
        end
        if (cs_n) begin
            cs_high_run <= cs_high_run + 1;
            if (cs_low_run > 0) last_cs_low_len <= cs_low_run;
            cs_low_run <= 0;
        end else begin
            cs_low_run <= cs_low_run + 1;
            cs_low_cyc <= cs_low_cyc + 1;
            if (cs_high_run > 0) last_cs_high_len <= cs_high_run;
            cs_high_run <= 0;
        end
        if (sclk) sclk_high_cyc <= sclk_high_cyc + 1;
        if (sclk && cs_n) viol <= viol + 1;
        if (mosi) mosi_ones <= mosi_ones + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic start_xfer(input logic [DW-1:0] tx);
        int base = acc_cnt;
        int n = 0;
        tx_data   = tx;
        req_valid = 1'b1;
        while (acc_cnt == base && n < 200) begin
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("accept", acc_cnt - base, 1);
    endtask

    task automatic wait_rsp(input int base);
        int n = 0;
        while (rsp_cnt == base && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Full transaction; expected rx is the sent word in loopback, else the MISO word.
    task automatic run_xfer(input string tag, input logic [DW-1:0] tx,
                            input logic lp, input logic [DW-1:0] pat);
        int            b_rise = rise_cnt;
        int            b_rsp  = rsp_cnt;
        logic [DW-1:0] exp_rx = lp ? tx : pat;
        loop_mode = lp;
        pattern   = pat;
        start_xfer(tx);
        wait_rsp(b_rsp);
        repeat (GAPC + 2) tick();
        check({tag, "_rsp_count"}, rsp_cnt - b_rsp, 1);
        check({tag, "_rx_log"}, rx_log[b_rsp % 64], exp_rx);
        check({tag, "_rx_port"}, rx_data, exp_rx);
        check({tag, "_sclk_rises"}, rise_cnt - b_rise, DW);
        check({tag, "_mosi_bits"}, mosi_hist, tx);
        check({tag, "_cs_low_len"}, last_cs_low_len, CS_LOW_EXP);
        check({tag, "_ready"}, req_ready, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int            b_acc, b_rsp, b_rise, b_ones, b_sclk, b_csl, n;
        logic [DW-1:0] rtx, rpat;
        logic          rlp;

        // Reset values
        repeat (3) tick();
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_mosi", mosi, 0);
        rst = 1'b0;

        // Idle after reset: bus quiet for 100 cycles
        b_rsp  = rsp_cnt;
        b_sclk = sclk_high_cyc;
        b_csl  = cs_low_cyc;
        repeat (100) tick();
        check("idle_sclk_high", sclk_high_cyc - b_sclk, 0);
        check("idle_cs_low", cs_low_cyc - b_csl, 0);
        check("idle_rsp", rsp_cnt - b_rsp, 0);

        // Loopback 0xA5
        run_xfer("loop_a5", 8'hA5, 1'b1, '0);

        // MISO tied high / low with tx = 0; MOSI must never go high
        b_ones = mosi_ones;
        run_xfer("miso_ones", 8'h00, 1'b0, 8'hFF);
        run_xfer("miso_zeros", 8'h00, 1'b0, 8'h00);
        check("tx0_mosi_high_cycles", mosi_ones - b_ones, 0);

        // Back-to-back with req_valid held high
        loop_mode = 1'b1;
        b_acc = acc_cnt;
        b_rsp = rsp_cnt;
        tx_data   = 8'h3C;
        req_valid = 1'b1;
        n = 0;
        while (acc_cnt == b_acc && n < 200) begin tick(); n++; end
        tx_data = 8'hC3;
        n = 0;
        while (acc_cnt < b_acc + 2 && n < 200) begin tick(); n++; end
        req_valid = 1'b0;
        check("b2b_accepts", acc_cnt - b_acc, 2);
        check("b2b_spacing", last_acc - prev_acc, SPACING_EXP);
        check("b2b_cs_high", last_cs_high_len, CS_GAP_EXP);
        n = 0;
        while (rsp_cnt < b_rsp + 2 && n < 200) begin tick(); n++; end
        check("b2b_rsp_count", rsp_cnt - b_rsp, 2);
        check("b2b_rx_first", rx_log[b_rsp % 64], 8'h3C);
        check("b2b_rx_second", rx_log[(b_rsp + 1) % 64], 8'hC3);
        repeat (GAPC + 2) tick();

        // Request pulsed while busy is ignored
        b_acc = acc_cnt;
        b_rsp = rsp_cnt;
        start_xfer(8'h5A);
        repeat (5) tick();
        tx_data   = 8'h99;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rsp(b_rsp);
        repeat (60) tick();
        check("busy_req_accepts", acc_cnt - b_acc, 1);
        check("busy_req_rsp_count", rsp_cnt - b_rsp, 1);
        check("busy_req_rx", rx_log[b_rsp % 64], 8'h5A);

        // Reset at the third SCLK rise aborts the transaction
        b_rsp  = rsp_cnt;
        b_rise = rise_cnt;
        start_xfer(8'h96);
        n = 0;
        while (rise_cnt - b_rise < 3 && n < 200) begin tick(); n++; end
        check("abort_third_rise", rise_cnt - b_rise, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", req_ready, 1);
        repeat (60) tick();
        check("abort_no_rsp", rsp_cnt - b_rsp, 0);
        run_xfer("after_abort", 8'h69, 1'b1, '0);

        // Randomized transactions
        for (int i = 0; i < 8; i++) begin
            rtx  = DW'($urandom);
            rpat = DW'($urandom);
            rlp  = ($urandom_range(0, 1) == 1);
            run_xfer($sformatf("rand%0d", i), rtx, rlp, rpat);
        end

        check("sclk_high_while_cs_high", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
